// File: rtl/reg_file_if.sv
// ---------------------------------------------------------------------------
// reg_file_if -- bus bundle for the two-read / one-write register file.
//
// Signals (direction given from the register file's point of view):
//   clear_i  in   one-cycle request to start a clear sweep
//   we_i     in   write enable
//   wa_i     in   write address
//   wd_i     in   write data
//   ra1_i    in   read address, port 1 (ALU operand A)
//   ra2_i    in   read address, port 2 (ALU operand B)
//   rd1_o    out  read data, port 1
//   rd2_o    out  read data, port 2
//   ready_o  out  file accepts writes and returns stored data
//
// Modports: master (datapath side, drives requests), slave (register file).
// ---------------------------------------------------------------------------
interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              clear_i;
    logic              we_i;
    logic [ADDR_W-1:0] wa_i;
    logic [DATA_W-1:0] wd_i;
    logic [ADDR_W-1:0] ra1_i;
    logic [ADDR_W-1:0] ra2_i;
    logic [DATA_W-1:0] rd1_o;
    logic [DATA_W-1:0] rd2_o;
    logic              ready_o;

    modport master (
        output clear_i, we_i, wa_i, wd_i, ra1_i, ra2_i,
        input  rd1_o, rd2_o, ready_o
    );

    modport slave (
        input  clear_i, we_i, wa_i, wd_i, ra1_i, ra2_i,
        output rd1_o, rd2_o, ready_o
    );
endinterface

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file -- two-read / one-write general-purpose register file feeding the
// ALU operands. Reads are combinational; register 0 is hard-wired to zero.
// After reset, or on a clear request, the array is zeroed by a sweep of one
// register per clock; ready_o is low for the whole sweep, during which writes
// and clear requests are ignored and both read ports return zero.
//
// Ports:
//   clk_i   in   clock, all state updates on the rising edge
//   rst_i   in   synchronous active-high reset (restarts the clear sweep)
//   bus     reg_file_if.slave: clear_i, we_i, wa_i, wd_i, ra1_i, ra2_i,
//           rd1_o, rd2_o, ready_o
//
// Optional feature: define REG_FILE_WRITE_BYPASS_EN to forward the write data
// combinationally to a read port addressing the register being written in the
// same cycle (never for register 0, never during a sweep).
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    reg_file_if.slave   bus
);

    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, ready_d;

    logic [DATA_W-1:0] mem_q [NREGS];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Next-state and array write port
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_d = ready_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        wr_data = '0;

        case (state_q)
            ST_CLEAR: begin
                // Sweep zeroes one register per edge; requests are ignored.
                wr_en   = 1'b1;
                wr_addr = ptr_q;
                wr_data = '0;
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    state_d = ST_READY;
                    ready_d = 1'b1;
                end
            end
            ST_READY: begin
                if (bus.clear_i) begin
                    // Clear takes priority over a coincident write.
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                    ready_d = 1'b0;
                end else if (bus.we_i && (bus.wa_i != '0)) begin
                    wr_en   = 1'b1;
                    wr_addr = bus.wa_i;
                    wr_data = bus.wd_i;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // Control registers; reset restarts the sweep from register 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
        end
    end

    // Storage array; contents are left untouched on a reset edge
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Combinational read ports
    always_comb begin
        bus.rd1_o = '0;
        bus.rd2_o = '0;
        if (ready_q) begin
            if (bus.ra1_i != '0) bus.rd1_o = mem_q[bus.ra1_i];
            if (bus.ra2_i != '0) bus.rd2_o = mem_q[bus.ra2_i];
`ifdef REG_FILE_WRITE_BYPASS_EN
            // Same-cycle forwarding; wa_i != 0 keeps register 0 out of it.
            if (!bus.clear_i && bus.we_i && (bus.wa_i != '0)) begin
                if (bus.ra1_i == bus.wa_i) bus.rd1_o = bus.wd_i;
                if (bus.ra2_i == bus.wa_i) bus.rd2_o = bus.wd_i;
            end
`endif
        end
    end

    assign bus.ready_o = ready_q;

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file -- self-checking bench for reg_file: directed sequences for the
// sweep/clear/reset corner cases, a vector table for writes and dual reads,
// and a randomized phase compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2 ** AW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: contents, readiness and edges spent in the sweep.
    // Reads are zero throughout a sweep and writes are dropped, so the model
    // simply zeroes the whole array once the sweep completes.
    logic [DW-1:0] m_mem [NR];
    bit            m_ready = 1'b0;
    int            m_cnt   = 0;

    task automatic model_edge();
        if (rst) begin
            m_ready = 1'b0;
            m_cnt   = 0;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == NR) begin
                m_ready = 1'b1;
                for (int i = 0; i < NR; i++) m_mem[i] = '0;
            end
        end else if (bus.clear_i) begin
            m_ready = 1'b0;
            m_cnt   = 0;
        end else if (bus.we_i && bus.wa_i != 0) begin
            m_mem[bus.wa_i] = bus.wd_i;
        end
    endtask

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] ra);
        if (!m_ready || ra == 0) return '0;
`ifdef REG_FILE_WRITE_BYPASS_EN
        if (bus.we_i && !bus.clear_i && bus.wa_i == ra) return bus.wd_i;
`endif
        return m_mem[ra];
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h00000000, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd5,  32'h00000001, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'd2,  32'h00000002, 5'd1,  5'd2,  32'h00000001, 32'h00000002};
        vecs[4] = '{1'b1, 5'd1,  32'h00000003, 5'd1,  5'd2,  32'h00000003, 32'h00000002};
        vecs[5] = '{1'b1, 5'd31, 32'h80000000, 5'd31, 5'd0,  32'h80000000, 32'h00000000};
        vecs[6] = '{1'b0, 5'd5,  32'h00012345, 5'd5,  5'd31, 32'hDEADBEEF, 32'h80000000};

        for (int i = 0; i < NR; i++) m_mem[i] = '0;
        bus.clear_i = 1'b0;
        bus.we_i    = 1'b0;
        bus.wa_i    = '0;
        bus.wd_i    = '0;
        bus.ra1_i   = 5'd7;
        bus.ra2_i   = 5'd31;

        // Reset sweep: two reset edges, then exactly NR edges to ready
        rst = 1'b1;
        tick();
        tick();
        check("reset_ready", {31'd0, bus.ready_o}, 32'd0);
        check("reset_rd1", bus.rd1_o, 32'd0);
        check("reset_rd2", bus.rd2_o, 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= NR; k++) begin
            tick();
            check("sweep_ready", {31'd0, bus.ready_o}, (k == NR) ? 32'd1 : 32'd0);
            check("sweep_rd1", bus.rd1_o, 32'd0);
            check("sweep_rd2", bus.rd2_o, 32'd0);
        end

        // Write r5 and read it on both ports; same-cycle read before the edge
        bus.we_i = 1'b1; bus.wa_i = 5'd5; bus.wd_i = 32'hDEADBEEF;
        bus.ra1_i = 5'd5; bus.ra2_i = 5'd5;
        #2;
`ifdef REG_FILE_WRITE_BYPASS_EN
        check("same_cycle_rd1", bus.rd1_o, 32'hDEADBEEF);
`else
        check("same_cycle_rd1", bus.rd1_o, 32'h0);
`endif
        tick();
        bus.we_i = 1'b0;
        #1;
        check("wr5_rd1", bus.rd1_o, 32'hDEADBEEF);
        check("wr5_rd2", bus.rd2_o, 32'hDEADBEEF);

        // Register 0 write is discarded and never bypassed
        bus.we_i = 1'b1; bus.wa_i = 5'd0; bus.wd_i = 32'hFFFFFFFF; bus.ra1_i = 5'd0;
        #2;
        check("r0_before", bus.rd1_o, 32'h0);
        tick();
        bus.we_i = 1'b0;
        #1;
        check("r0_after", bus.rd1_o, 32'h0);

        // Vector table: writes on consecutive edges, reads checked between
        for (int i = 0; i < 7; i++) begin
            bus.we_i = vecs[i].we; bus.wa_i = vecs[i].wa; bus.wd_i = vecs[i].wd;
            bus.ra1_i = vecs[i].ra1; bus.ra2_i = vecs[i].ra2;
            tick();
            bus.we_i = 1'b0;
            #1;
            check($sformatf("vec%0d_rd1", i), bus.rd1_o, vecs[i].exp1);
            check($sformatf("vec%0d_rd2", i), bus.rd2_o, vecs[i].exp2);
        end

        // Clear request wins over a coincident write; sweep ignores requests
        bus.we_i = 1'b1; bus.wa_i = 5'd3; bus.wd_i = 32'h12345678;
        tick();
        bus.wa_i = 5'd4; bus.wd_i = 32'h0BADF00D;
        tick();
        bus.clear_i = 1'b1; bus.we_i = 1'b1; bus.wa_i = 5'd4; bus.wd_i = 32'hAAAA5555;
        bus.ra1_i = 5'd3; bus.ra2_i = 5'd4;
        #2;
        check("clr_pre_rd1", bus.rd1_o, 32'h12345678);
        check("clr_pre_rd2", bus.rd2_o, 32'h0BADF00D);
        tick();
        check("clr_ready_drop", {31'd0, bus.ready_o}, 32'd0);
        for (int k = 1; k <= NR; k++) begin
            bus.clear_i = (k == 5);
            bus.we_i = 1'b1; bus.wa_i = AW'(k % 31 + 1); bus.wd_i = $urandom;
            #1;
            check("clr_sweep_rd1", bus.rd1_o, 32'h0);
            tick();
            check("clr_sweep_ready", {31'd0, bus.ready_o}, (k == NR) ? 32'd1 : 32'd0);
        end
        bus.clear_i = 1'b0; bus.we_i = 1'b0;
        #1;
        check("clr_r3", bus.rd1_o, 32'h0);
        check("clr_r4", bus.rd2_o, 32'h0);

        // Reset mid-sweep: fill the file, clear, reset 10 edges in
        for (int r = 1; r < NR; r++) begin
            bus.we_i = 1'b1; bus.wa_i = AW'(r); bus.wd_i = $urandom | 32'h1;
            tick();
        end
        bus.we_i = 1'b0;
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        check("midrst_ready", {31'd0, bus.ready_o}, 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= NR; k++) begin
            tick();
            check("midrst_sweep_ready", {31'd0, bus.ready_o}, (k == NR) ? 32'd1 : 32'd0);
        end
        for (int r = 0; r < NR; r++) begin
            bus.ra1_i = AW'(r); bus.ra2_i = AW'(NR - 1 - r);
            #1;
            check($sformatf("midrst_r%0d_p1", r), bus.rd1_o, 32'h0);
            check($sformatf("midrst_r%0d_p2", r), bus.rd2_o, 32'h0);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom % 300 == 0);
            bus.clear_i = ($urandom % 60 == 0);
            bus.we_i    = ($urandom % 3 != 0);
            bus.wa_i    = AW'($urandom);
            bus.wd_i    = $urandom;
            bus.ra1_i   = ($urandom % 4 == 0) ? bus.wa_i : AW'($urandom);
            bus.ra2_i   = ($urandom % 4 == 0) ? bus.wa_i : AW'($urandom);
            #2;
            check("rand_ready", {31'd0, bus.ready_o}, {31'd0, m_ready});
            check("rand_rd1", bus.rd1_o, m_read(bus.ra1_i));
            check("rand_rd2", bus.rd2_o, m_read(bus.ra2_i));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
